pipe_stage_buf: RTL and testbench

//  Parametrised inter-stage pipeline buffer (IF/ID, ID/EX, EX/MEM, MEM/WB) replacing fixed per-stage regs.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_slot.sv | 37 +++
 rtl/pipe_stage_buf.sv | 91 +++++++++
 tb/tb_pipe_stage_buf.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline buffers: per-stage payload widths,
// control-field bit offsets and the NOP control word.
package pipe_pkg;

  typedef enum logic [1:0] {
    STAGE_IFID  = 2'd0,
    STAGE_IDEX  = 2'd1,
    STAGE_EXMEM = 2'd2,
    STAGE_MEMWB = 2'd3
  } pipe_stage_e;

  localparam int DEF_DATA_W   = 160;
  localparam int DEF_CTRL_W   = 32;
  localparam int DEF_CNT_W    = 16;

  localparam int IFID_DATA_W  = 64;   // IR + PC
  localparam int IFID_CTRL_W  = 8;
  localparam int IDEX_DATA_W  = 160;  // PC, rs1, rs2, imm, IR
  localparam int IDEX_CTRL_W  = 32;
  localparam int EXMEM_DATA_W = 128;
  localparam int EXMEM_CTRL_W = 16;
  localparam int MEMWB_DATA_W = 96;
  localparam int MEMWB_CTRL_W = 8;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_JUMP       = 5;
  localparam int CTRL_ALU_SRC    = 6;
  localparam int CTRL_ALU_OP_LSB = 8;
  localparam int CTRL_ALU_OP_W   = 4;

  localparam logic [31:0] NOP_CTRL = 32'h0;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot {valid, ctrl, data}. Clearing always returns ctrl to NOP so an empty
// slot reads as a bubble; data is zeroed on clear only when CLR_DATA is set.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter int CLR_DATA = 0
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              clear,
  input  logic              load,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (CLR) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= CTRL_W'(NOP_CTRL);
      if (CLR_DATA != 0) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
      data  <= ld_data;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between pipeline stages with flush and hazard hold.
// Define PIPE_STAGE_PERF_EN to add saturating stall_cnt / bubble_cnt outputs.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter int CLR_DATA = 0
`ifdef PIPE_STAGE_PERF_EN
  , parameter int CNT_W  = DEF_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
`endif
);

  logic              h_v, s_v;
  logic [CTRL_W-1:0] h_ctrl, s_ctrl;
  logic [DATA_W-1:0] h_data, s_data;
  logic              accept, drain;
  logic              h_load, h_clear, s_load, s_clear;

  // Ready depends on registered state only, so no comb path from out_ready.
  assign in_ready = !s_v && !hold;
  assign accept   = in_valid && in_ready;
  assign drain    = h_v && out_ready;

  // H refills from S when S holds a word, otherwise from the input.
  assign h_load  = !flush && ((drain && (s_v || accept)) || (!h_v && accept));
  assign h_clear = flush || (drain && !s_v && !accept);
  assign s_load  = !flush && !drain && h_v && accept;
  assign s_clear = flush || (drain && s_v);

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLR_DATA(CLR_DATA)) u_head (
    .clk     (clk),
    .CLR     (CLR),
    .clear   (h_clear),
    .load    (h_load),
    .ld_ctrl (s_v ? s_ctrl : in_ctrl),
    .ld_data (s_v ? s_data : in_data),
    .valid   (h_v),
    .ctrl    (h_ctrl),
    .data    (h_data)
  );

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLR_DATA(CLR_DATA)) u_skid (
    .clk     (clk),
    .CLR     (CLR),
    .clear   (s_clear),
    .load    (s_load),
    .ld_ctrl (in_ctrl),
    .ld_data (in_data),
    .valid   (s_v),
    .ctrl    (s_ctrl),
    .data    (s_data)
  );

  assign out_valid = h_v;
  assign out_ctrl  = h_ctrl;
  assign out_data  = h_data;
  assign occupancy = {1'b0, h_v} + {1'b0, s_v};

`ifdef PIPE_STAGE_PERF_EN
  // Counters survive flush; only CLR resets them.
  always_ff @(posedge clk) begin
    if (CLR) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (!out_valid && out_ready && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: accepted words are queued by a depth-2 FIFO model,
// a negedge monitor compares the DUT head, occupancy and ready against the queue.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int DW = 160;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          CLR, flush, hold, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt, bubble_cnt;
  logic [1:0]  stall_cnt2, bubble_cnt2;
  logic        in_ready2, out_valid2;
  logic [DW-1:0] out_data2;
  logic [CW-1:0] out_ctrl2;
  logic [1:0]  occupancy2;
`endif

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CLR_DATA(0)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W(16)
`endif
  ) dut (
    .clk       (clk),
    .CLR       (CLR),
    .flush     (flush),
    .hold      (hold),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt (stall_cnt),
    .bubble_cnt  (bubble_cnt)
`endif
  );

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CLR_DATA(0), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .CLR        (CLR),
    .flush      (flush),
    .hold       (hold),
    .in_valid   (in_valid),
    .in_ready   (in_ready2),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid2),
    .out_ready  (out_ready),
    .out_data   (out_data2),
    .out_ctrl   (out_ctrl2),
    .occupancy  (occupancy2),
    .stall_cnt  (stall_cnt2),
    .bubble_cnt (bubble_cnt2)
  );
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } word_t;

  word_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    seq      = 0;
  int    m_stall  = 0;
  int    m_bubble = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a two-deep FIFO whose ready is decided by its size before the edge.
  int  sz;
  bit  m_ready;
  always @(posedge clk) begin
    sz      = q.size();
    m_ready = (sz < 2) && !hold;
    if (CLR) begin
      q.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (in_valid && !m_ready) m_stall++;
      if (sz == 0 && out_ready) m_bubble++;
      if (flush) q.delete();
      else begin
        if (sz > 0 && out_ready) void'(q.pop_front());
        if (in_valid && m_ready) q.push_back({in_data, in_ctrl});
      end
    end
  end

  always @(negedge clk) begin
    chk("occupancy", 192'(occupancy), 192'(q.size()));
    chk("out_valid", 192'(out_valid), 192'(q.size() > 0));
    chk("in_ready", 192'(in_ready), 192'((q.size() < 2) && !hold));
    if (q.size() > 0) begin
      chk("out_data", 192'(out_data), 192'(q[0].d));
      chk("out_ctrl", 192'(out_ctrl), 192'(q[0].c));
    end else begin
      chk("out_ctrl_nop", 192'(out_ctrl), 192'(0));
    end
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", 192'(stall_cnt), 192'(m_stall > 65535 ? 65535 : m_stall));
    chk("bubble_cnt", 192'(bubble_cnt), 192'(m_bubble > 65535 ? 65535 : m_bubble));
    chk("stall_cnt_sat", 192'(stall_cnt2), 192'(m_stall > 3 ? 3 : m_stall));
    chk("bubble_cnt_sat", 192'(bubble_cnt2), 192'(m_bubble > 3 ? 3 : m_bubble));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_word();
    seq++;
    in_data = {$urandom(), $urandom(), $urandom(), $urandom(), 32'(seq)};
    in_ctrl = {16'(seq), 16'($urandom()) | 16'h1};
  endtask

  task automatic drive(input bit iv, input bit ordy, input bit hd, input bit fl);
    in_valid  = iv;
    out_ready = ordy;
    hold      = hd;
    flush     = fl;
    new_word();
    step();
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    CLR = 1'b0;
    @(negedge clk);
    chk("reset_out_data", 192'(out_data), 192'(0));
    chk("reset_in_ready", 192'(in_ready), 192'(1));
    #1;
  endtask

  initial begin
    CLR = 1'b1; flush = 1'b0; hold = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    do_reset();

    // back-pressure / bubble warm-up: 3 empty-ready cycles then stalls
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);

    // streaming at full rate
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);

    // downstream stalls three cycles, then releases
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);

    // flush with both slots full and a word offered
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk("flush_empty", 192'(occupancy), 192'(0));
    drive(1'b0, 1'b1, 1'b0, 1'b0);

    // hazard hold while head drains
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);

    // reset mid-stream
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();

    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
